// File: rtl/rx_edge_bit_sampler.sv
// UART RX timing/sampling stage: counts oversampling edges and bit periods,
// and majority-votes three mid-bit RX_IN samples into sampled_bit.
module rx_edge_bit_sampler #(
   parameter int prescale_width = 6,
   parameter int edge_cnt_width = 6,
   parameter int bit_cnt_width  = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic                      cnt_en,
   input  logic [prescale_width-1:0] prescale,
   output logic [edge_cnt_width-1:0] edge_cnt,
   output logic [bit_cnt_width-1:0]  bit_cnt,
   output logic                      sampled_bit,
   output logic                      sample_done
);

   localparam logic [edge_cnt_width-1:0] EDGE_ZERO = {edge_cnt_width{1'b0}};
   localparam logic [edge_cnt_width-1:0] EDGE_ONE  = edge_cnt_width'(1'b1);
   localparam logic [bit_cnt_width-1:0]  BIT_ZERO  = {bit_cnt_width{1'b0}};
   localparam logic [bit_cnt_width-1:0]  BIT_ONE   = bit_cnt_width'(1'b1);
   localparam logic [bit_cnt_width-1:0]  BIT_MAX   = {bit_cnt_width{1'b1}};

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [edge_cnt_width-1:0] edge_cnt_r, edge_cnt_nxt_s;
   logic [bit_cnt_width-1:0]  bit_cnt_r, bit_cnt_nxt_s;
   logic                      sampled_bit_r, sampled_bit_nxt_s;
   logic                      sample_done_r, sample_done_nxt_s;
   logic                      s0_r, s0_nxt_s;
   logic                      s1_r, s1_nxt_s;

   logic [edge_cnt_width-1:0] prescale_ext_s;
   logic [edge_cnt_width-1:0] half_s;
   logic [edge_cnt_width-1:0] half_m1_s;
   logic [edge_cnt_width-1:0] half_p1_s;
   logic [edge_cnt_width-1:0] last_s;

   assign prescale_ext_s = edge_cnt_width'(prescale);
   assign half_s         = prescale_ext_s >> 1;
   assign half_m1_s      = half_s - EDGE_ONE;
   assign half_p1_s      = half_s + EDGE_ONE;
   // ">=" forces a wrap even if prescale shrinks below the current edge index
   assign last_s         = prescale_ext_s - EDGE_ONE;

   // Next-state: edge/bit counting and three-point mid-bit vote
   always_comb begin
      edge_cnt_nxt_s    = edge_cnt_r;
      bit_cnt_nxt_s     = bit_cnt_r;
      sampled_bit_nxt_s = sampled_bit_r;
      sample_done_nxt_s = 1'b0;
      s0_nxt_s          = s0_r;
      s1_nxt_s          = s1_r;
      if (!cnt_en) begin
         edge_cnt_nxt_s = EDGE_ZERO;
         bit_cnt_nxt_s  = BIT_ZERO;
      end else begin
         if (edge_cnt_r >= last_s) begin
            edge_cnt_nxt_s = EDGE_ZERO;
            if (bit_cnt_r != BIT_MAX) begin
               bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
            end else begin
               bit_cnt_nxt_s = bit_cnt_r;
            end
         end else begin
            edge_cnt_nxt_s = edge_cnt_r + EDGE_ONE;
         end

         if (edge_cnt_r == half_m1_s) begin
            s0_nxt_s = RX_IN;
         end else if (edge_cnt_r == half_s) begin
            s1_nxt_s = RX_IN;
         end else if (edge_cnt_r == half_p1_s) begin
            sampled_bit_nxt_s = maj3(s0_r, s1_r, RX_IN);
            sample_done_nxt_s = 1'b1;
         end else begin
            sample_done_nxt_s = 1'b0;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         edge_cnt_r    <= EDGE_ZERO;
         bit_cnt_r     <= BIT_ZERO;
         sampled_bit_r <= 1'b0;
         sample_done_r <= 1'b0;
         s0_r          <= 1'b0;
         s1_r          <= 1'b0;
      end else begin
         edge_cnt_r    <= edge_cnt_nxt_s;
         bit_cnt_r     <= bit_cnt_nxt_s;
         sampled_bit_r <= sampled_bit_nxt_s;
         sample_done_r <= sample_done_nxt_s;
         s0_r          <= s0_nxt_s;
         s1_r          <= s1_nxt_s;
      end
   end

   assign edge_cnt    = edge_cnt_r;
   assign bit_cnt     = bit_cnt_r;
   assign sampled_bit = sampled_bit_r;
   assign sample_done = sample_done_r;

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Self-checking bench for rx_edge_bit_sampler: vector table applied per cycle,
// expected post-edge outputs queued in a scoreboard and compared after each posedge.
module tb_rx_edge_bit_sampler;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic       cnt_en;
   logic [5:0] prescale;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       sampled_bit;
   logic       sample_done;

   rx_edge_bit_sampler #(
      .prescale_width(6),
      .edge_cnt_width(6),
      .bit_cnt_width (4)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .cnt_en     (cnt_en),
      .prescale   (prescale),
      .edge_cnt   (edge_cnt),
      .bit_cnt    (bit_cnt),
      .sampled_bit(sampled_bit),
      .sample_done(sample_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic       en;
      logic       rx;
      logic [5:0] ps;
      logic [5:0] e_cnt;
      logic [3:0] b_cnt;
      logic       s_bit;
      logic       done;
      int         seg;
   } vec_t;

   vec_t        vecs[$];
   logic [11:0] sb_q[$];
   string       seg_name[6] = '{"reset", "count8", "vote8", "disable16", "sat32", "shrink"};
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic void add(input logic rst, input logic en, input logic rx,
                               input logic [5:0] ps, input logic [5:0] e,
                               input logic [3:0] b, input logic s, input logic d,
                               input int seg);
      vec_t v;
      v.rst = rst; v.en = en; v.rx = rx; v.ps = ps;
      v.e_cnt = e; v.b_cnt = b; v.s_bit = s; v.done = d; v.seg = seg;
      vecs.push_back(v);
   endfunction

   function automatic logic vote(input logic [2:0] p);
      int n;
      n = int'(p[0]) + int'(p[1]) + int'(p[2]);
      return (n >= 2);
   endfunction

   task automatic cmp(input string name, input int idx, input logic [11:0] got,
                      input logic [11:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got edge=%0d bit=%0d sb=%b done=%b, required edge=%0d bit=%0d sb=%b done=%b",
                  name, idx, got[11:6], got[5:2], got[1], got[0],
                  exp[11:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   initial begin
      int          k;
      int          e;
      logic [2:0]  p;
      logic        rx;
      logic        sbe;
      logic [11:0] exp_v;

      RST = 1'b0; cnt_en = 1'b0; RX_IN = 1'b0; prescale = 6'd8;

      // reset held two cycles with enable on and RX toggling
      for (int i = 0; i < 2; i++) add(1'b0, 1'b1, i[0], 6'd8, 6'd0, 4'd0, 1'b0, 1'b0, 0);

      // prescale 8 free count over 17 cycles, RX low
      for (int i = 0; i < 17; i++)
         add(1'b1, 1'b1, 1'b0, 6'd8, 6'((i + 1) % 8), 4'((i + 1) / 8), 1'b0,
             ((i + 1) % 8) == 6, 1);
      add(1'b1, 1'b0, 1'b0, 6'd8, 6'd0, 4'd0, 1'b0, 1'b0, 1);

      // vote 1,0,1 then 0,0,1 with glitches off the vote edges
      for (int j = 0; j < 16; j++) begin
         e = j % 8;
         if (j < 8) rx = (e == 3 || e == 5);
         else       rx = !(e == 3 || e == 4);
         sbe = (j >= 5 && j < 13);
         add(1'b1, 1'b1, rx, 6'd8, 6'((j + 1) % 8), 4'((j + 1) / 8), sbe,
             ((j + 1) % 8) == 6, 2);
      end
      add(1'b1, 1'b0, 1'b1, 6'd8, 6'd0, 4'd0, 1'b0, 1'b0, 2);

      // prescale 16, drop enable at edge 9 of bit 2; sampled_bit must hold 1
      for (int i = 0; i < 41; i++) begin
         rx = !(i >= 32 && (i % 16) >= 7);
         add(1'b1, 1'b1, rx, 6'd16, 6'((i + 1) % 16), 4'((i + 1) / 16), i >= 9,
             ((i + 1) % 16) == 10, 3);
      end
      add(1'b1, 1'b0, 1'b0, 6'd16, 6'd0, 4'd0, 1'b1, 1'b0, 3);
      add(1'b1, 1'b0, 1'b1, 6'd16, 6'd0, 4'd0, 1'b1, 1'b0, 3);

      // prescale 32 for 17 bit periods, varying vote patterns, bit_cnt saturates
      for (int i = 0; i < 544; i++) begin
         k = i / 32;
         e = i % 32;
         p = 3'(k % 8);
         if (e == 15)      rx = p[0];
         else if (e == 16) rx = p[1];
         else if (e == 17) rx = p[2];
         else              rx = i[0];
         if (e >= 17)      sbe = vote(p);
         else if (k == 0)  sbe = 1'b1;
         else              sbe = vote(3'((k - 1) % 8));
         add(1'b1, 1'b1, rx, 6'd32, 6'((i + 1) % 32),
             4'(((i + 1) / 32) > 15 ? 15 : ((i + 1) / 32)), sbe, e == 17, 4);
      end
      add(1'b1, 1'b0, 1'b0, 6'd32, 6'd0, 4'd0, 1'b0, 1'b0, 4);

      // prescale shrinks 16 -> 8 while edge_cnt is 12
      for (int i = 0; i < 13; i++)
         add(1'b1, 1'b1, 1'b1, (i == 12) ? 6'd8 : 6'd16, (i == 12) ? 6'd0 : 6'(i + 1),
             (i == 12) ? 4'd1 : 4'd0, i >= 9, (i + 1) == 10, 5);
      for (int i = 0; i < 2; i++)
         add(1'b1, 1'b1, 1'b1, 6'd8, 6'(i + 1), 4'd1, 1'b1, 1'b0, 5);

      for (int n = 0; n < vecs.size(); n++) begin
         @(negedge CLK);
         RST      = vecs[n].rst;
         cnt_en   = vecs[n].en;
         RX_IN    = vecs[n].rx;
         prescale = vecs[n].ps;
         sb_q.push_back({vecs[n].e_cnt, vecs[n].b_cnt, vecs[n].s_bit, vecs[n].done});
         @(posedge CLK);
         #1;
         exp_v = sb_q.pop_front();
         cmp(seg_name[vecs[n].seg], n, {edge_cnt, bit_cnt, sampled_bit, sample_done}, exp_v);
      end

      // reset asserted mid-cycle: nothing changes until the next posedge
      @(negedge CLK);
      RST = 1'b0;
      cnt_en = 1'b1;
      #2;
      cmp("rst_mid_hold", 0, {edge_cnt, bit_cnt, sampled_bit, sample_done},
          {6'd2, 4'd1, 1'b1, 1'b0});
      @(posedge CLK);
      #1;
      cmp("rst_mid_apply", 0, {edge_cnt, bit_cnt, sampled_bit, sample_done},
          {6'd0, 4'd0, 1'b0, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
